// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller with frame-synchronous shadowed updates
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_HZ         = 100_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int BRIGHT_W       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     bright,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_n;
    logic                    tick;
    logic                    boundary;

    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic                    pend_flag;

    logic [4*NUM_DIGITS-1:0] act_data;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_blank;
    logic [4*NUM_DIGITS-1:0] act_data_n;
    logic [NUM_DIGITS-1:0]   act_dp_n;
    logic [NUM_DIGITS-1:0]   act_blank_n;

    logic [BRIGHT_W-1:0]     pwm_cnt;
    logic                    pwm_on;

    logic [3:0]              nib;
    logic [NUM_DIGITS-1:0]   sel_n;
    logic                    blank_sel;
    logic                    dp_sel;
    logic                    lz_dark;
    logic [6:0]              seg_n;
    logic                    dp_n;

    logic [NUM_DIGITS-1:0]   sel_r;
    logic [6:0]              seg_r;
    logic                    dp_r;
    logic                    frame_r;

    assign tick     = (div_cnt == DIV_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    always_comb begin
        idx_n = idx;
        if (tick) begin
            idx_n = boundary ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
            pwm_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            idx     <= idx_n;
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // A load landing on the boundary bypasses the shadow and wins over any older pending value.
    always_comb begin
        act_data_n  = act_data;
        act_dp_n    = act_dp;
        act_blank_n = act_blank;
        if (boundary && load) begin
            act_data_n  = data;
            act_dp_n    = dp_in;
            act_blank_n = blank_in;
        end else if (boundary && pend_flag) begin
            act_data_n  = pend_data;
            act_dp_n    = pend_dp;
            act_blank_n = pend_blank;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_flag  <= 1'b0;
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
        end else begin
            if (load) begin
                pend_data  <= data;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
                pend_flag  <= !boundary;
            end else if (boundary) begin
                pend_flag  <= 1'b0;
            end
            act_data  <= act_data_n;
            act_dp    <= act_dp_n;
            act_blank <= act_blank_n;
        end
    end

    // Output registers look at next-cycle index/data so they change together with them.
    always_comb begin
        nib       = 4'h0;
        sel_n     = '0;
        blank_sel = 1'b0;
        dp_sel    = 1'b0;
        lz_dark   = (idx_n != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(idx_n) == i) begin
                nib       = act_data_n[4*i +: 4];
                sel_n[i]  = 1'b1;
                blank_sel = act_blank_n[i];
                dp_sel    = act_dp_n[i];
            end
            if (i >= int'(idx_n) && act_data_n[4*i +: 4] != 4'h0) begin
                lz_dark = 1'b0;
            end
        end
        seg_n  = (blank_sel || (lz_suppress && lz_dark)) ? 7'h00 : hex_to_seg(nib);
        dp_n   = dp_sel && !blank_sel;
        pwm_on = (&bright) || (pwm_cnt < bright);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_r   <= '0;
            seg_r   <= '0;
            dp_r    <= 1'b0;
            frame_r <= 1'b0;
        end else begin
            sel_r   <= pwm_on ? sel_n : '0;
            seg_r   <= seg_n;
            dp_r    <= dp_n;
            frame_r <= boundary;
        end
    end

    assign digit_sel   = AN_ACTIVE_LOW  ? ~sel_r : sel_r;
    assign seg         = SEG_ACTIVE_LOW ? ~seg_r : seg_r;
    assign dp          = SEG_ACTIVE_LOW ? ~dp_r  : dp_r;
    assign frame_start = frame_r;
    assign pending     = pend_flag;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

    localparam int N  = 4;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4*N-1:0] data = '0;
    logic [N-1:0]  dp_in = '0;
    logic [N-1:0]  blank_in = '0;
    logic          load = 1'b0;
    logic          lz_suppress = 1'b0;
    logic [BW-1:0] bright = 2'd3;
    logic [N-1:0]  digit_sel;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_start;
    logic          pending;

    int checks   = 0;
    int failures = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS(N), .CLK_HZ(80), .SCAN_HZ(10), .BRIGHT_W(BW),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .blank_in(blank_in),
        .load(load), .lz_suppress(lz_suppress), .bright(bright),
        .digit_sel(digit_sel), .seg(seg), .dp(dp),
        .frame_start(frame_start), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
    } obs_t;

    typedef struct packed {
        logic [15:0]     data;
        logic [3:0]      dpm;
        logic [3:0]      blank;
        logic            lz;
        logic [3:0][6:0] s;
        logic [3:0]      edp;
    } vec_t;

    obs_t sb_q[$];
    vec_t vecs[8];
    vec_t prev;

    function automatic vec_t mk(input logic [15:0] d, input logic [3:0] dpm, input logic [3:0] bl,
                                input logic lz, input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] edp);
        vec_t v;
        v.data  = d;
        v.dpm   = dpm;
        v.blank = bl;
        v.lz    = lz;
        v.s     = {s3, s2, s1, s0};
        v.edp   = edp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 80);
        if (!frame_start) begin
            checks++;
            failures++;
            $display("FAIL %s frame_start timeout", name);
        end
    endtask

    task automatic push_digit(input vec_t v, input int k);
        obs_t o;
        o.sel = 4'(1 << k);
        o.seg = v.s[k];
        o.dp  = v.edp[k];
        sb_q.push_back(o);
    endtask

    task automatic sample_pop(input string name);
        obs_t got;
        obs_t want;
        got.sel = digit_sel;
        got.seg = seg;
        got.dp  = dp;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty actual=%h", name, got);
        end else begin
            want = sb_q.pop_front();
            check(name, 32'(got), 32'(want));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt[4];
        int bad;
        bit pend_seen;

        vecs[0] = mk(16'h1234, 4'b0000, 4'b0000, 1'b0, 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0000);
        vecs[1] = mk(16'hABCD, 4'b0000, 4'b0000, 1'b0, 7'h77, 7'h7C, 7'h39, 7'h5E, 4'b0000);
        vecs[2] = mk(16'h0070, 4'b0000, 4'b0000, 1'b1, 7'h00, 7'h00, 7'h07, 7'h3F, 4'b0000);
        vecs[3] = mk(16'h0000, 4'b0000, 4'b0000, 1'b1, 7'h00, 7'h00, 7'h00, 7'h3F, 4'b0000);
        vecs[4] = mk(16'h0000, 4'b0000, 4'b0000, 1'b0, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
        vecs[5] = mk(16'h5678, 4'b0101, 4'b0010, 1'b0, 7'h6D, 7'h7D, 7'h00, 7'h7F, 4'b0101);
        vecs[6] = mk(16'h0E0F, 4'b1000, 4'b0000, 1'b1, 7'h00, 7'h79, 7'h3F, 7'h71, 4'b1000);
        vecs[7] = mk(16'h9000, 4'b0000, 4'b0000, 1'b1, 7'h6F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
        prev    = mk(16'h0000, 4'b0000, 4'b0000, 1'b0, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);

        #2;
        check("rst_digit_sel", 32'(digit_sel), 32'h0);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_flags", 32'({dp, frame_start, pending}), 32'h0);
        step(2);
        check("rst_hold_sel", 32'(digit_sel), 32'h0);
        rst = 1'b0;

        wait_frame("first_frame");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 80);
        check("frame_period", 32'(n), 32'd32);

        for (int v = 0; v < 8; v++) begin
            wait_frame($sformatf("vec%0d_sync", v));
            step(10);
            data     = vecs[v].data;
            dp_in    = vecs[v].dpm;
            blank_in = vecs[v].blank;
            load     = 1'b1;
            @(negedge clk);
            load = 1'b0;
            check($sformatf("vec%0d_pending_set", v), 32'(pending), 32'd1);
            push_digit(prev, 2);
            push_digit(prev, 3);
            step(5);
            sample_pop($sformatf("vec%0d_old_slot2", v));
            step(8);
            sample_pop($sformatf("vec%0d_old_slot3", v));
            for (int k = 0; k < 4; k++) push_digit(vecs[v], k);
            wait_frame($sformatf("vec%0d_apply", v));
            check($sformatf("vec%0d_pending_clr", v), 32'(pending), 32'd0);
            sample_pop($sformatf("vec%0d_slot0", v));
            lz_suppress = vecs[v].lz;
            for (int k = 1; k < 4; k++) begin
                step(8);
                sample_pop($sformatf("vec%0d_slot%0d", v, k));
            end
            prev = vecs[v];
        end

        for (int b = 0; b < 3; b++) begin
            bright = (b == 0) ? 2'd1 : (b == 1) ? 2'd0 : 2'd3;
            wait_frame($sformatf("pwm%0d_sync", b));
            for (int k = 0; k < 4; k++) cnt[k] = 0;
            bad = 0;
            for (int i = 0; i < 32; i++) begin
                if (digit_sel != 4'b0) begin
                    cnt[i/8]++;
                    if (digit_sel != 4'(1 << (i/8))) bad++;
                end
                if (seg != prev.s[i/8]) bad++;
                @(negedge clk);
            end
            for (int k = 0; k < 4; k++)
                check($sformatf("pwm_b%0d_slot%0d_on", bright, k), 32'(cnt[k]),
                      (b == 0) ? 32'd2 : (b == 1) ? 32'd0 : 32'd8);
            check($sformatf("pwm_b%0d_shape", bright), 32'(bad), 32'd0);
        end

        wait_frame("bnd_sync");
        step(31);
        data     = 16'h4321;
        dp_in    = 4'b0000;
        blank_in = 4'b0000;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("bnd_frame_start", 32'(frame_start), 32'd1);
        check("bnd_digit0", 32'({digit_sel, seg}), 32'({4'b0001, 7'h06}));
        pend_seen = pending;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pend_seen |= pending;
        end
        check("bnd_digit1", 32'({digit_sel, seg}), 32'({4'b0010, 7'h5B}));
        check("bnd_no_pending", 32'(pend_seen), 32'd0);

        wait_frame("rst_sync");
        step(5);
        data = 16'hBEEF;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("mid_pending_set", 32'(pending), 32'd1);
        step(6);
        #2 rst = 1'b1;
        #1;
        check("async_rst_sel", 32'(digit_sel), 32'h0);
        check("async_rst_seg", 32'({seg, dp}), 32'h0);
        check("async_rst_flags", 32'({frame_start, pending}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        check("post_rst_d0", 32'({digit_sel, seg}), 32'({4'b0001, 7'h3F}));
        step(6);
        check("post_rst_d0_last", 32'(digit_sel), 32'h1);
        step(1);
        check("post_rst_d1", 32'({digit_sel, seg}), 32'({4'b0010, 7'h00}));
        step(23);
        check("post_rst_no_fs", 32'({frame_start, pending}), 32'h0);
        step(1);
        check("post_rst_fs", 32'(frame_start), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
